// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, issues one outstanding word read at a time,
// buffers the returned word and hands {pc, inst} to decode over valid/ready.
module ifu_fetch #(
   parameter int                 ADDR_W   = 64,
   parameter int                 INST_W   = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC = 64'h0000_0000_8000_0000
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_req_addr,
   input  logic              mem_resp_valid,
   input  logic [INST_W-1:0] mem_resp_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_pc,
   output logic [INST_W-1:0] out_inst,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              halt,
   output logic              fetch_fault
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_REQ  = 3'd1,
      ST_WAIT = 3'd2,
      ST_HOLD = 3'd3,
      ST_HALT = 3'd4
   } state_t;

   localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

   state_t              state_r, state_s;
   logic [ADDR_W-1:0]   pc_r, pc_s;
   logic                kill_r, kill_s;
   logic                req_valid_r, req_valid_s;
   logic                out_valid_r, out_valid_s;
   logic [ADDR_W-1:0]   out_pc_r, out_pc_s;
   logic [INST_W-1:0]   out_inst_r, out_inst_s;
   logic                fault_r, fault_s;
   logic                mis_s;
   logic                stop_s;
   state_t              resume_s;

   // Next-state and next-output computation; redirect overrides every other event.
   always_comb begin
      state_s     = state_r;
      pc_s        = pc_r;
      kill_s      = kill_r;
      out_valid_s = out_valid_r;
      out_pc_s    = out_pc_r;
      out_inst_s  = out_inst_r;
      fault_s     = fault_r;
      mis_s       = redirect_valid & (redirect_pc[1:0] != 2'b00);
      stop_s      = halt | fault_r | mis_s;
      resume_s    = stop_s ? ST_HALT : ST_REQ;

      case (state_r)
         ST_IDLE: begin
            state_s = resume_s;
         end
         ST_REQ: begin
            // An accepted request cannot be recalled, so its response is killed instead.
            if (redirect_valid) begin
               if (mem_req_ready) begin
                  kill_s  = 1'b1;
                  state_s = ST_WAIT;
               end else begin
                  state_s = resume_s;
               end
            end else if (mem_req_ready) begin
               state_s = ST_WAIT;
            end else if (halt) begin
               state_s = ST_HALT;
            end else begin
               state_s = ST_REQ;
            end
         end
         ST_WAIT: begin
            if (redirect_valid) begin
               if (mem_resp_valid) begin
                  kill_s  = 1'b0;
                  state_s = resume_s;
               end else begin
                  kill_s  = 1'b1;
                  state_s = ST_WAIT;
               end
            end else if (mem_resp_valid) begin
               if (kill_r) begin
                  kill_s  = 1'b0;
                  state_s = resume_s;
               end else begin
                  out_valid_s = 1'b1;
                  out_pc_s    = pc_r;
                  out_inst_s  = mem_resp_data;
                  pc_s        = pc_r + PC_STEP;
                  state_s     = ST_HOLD;
               end
            end else begin
               state_s = ST_WAIT;
            end
         end
         ST_HOLD: begin
            if (redirect_valid) begin
               state_s = resume_s;
            end else if (out_ready) begin
               out_valid_s = 1'b0;
               state_s     = resume_s;
            end else begin
               state_s = ST_HOLD;
            end
         end
         ST_HALT: begin
            state_s = ST_HALT;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase

      // Held instruction is wrong-path once a redirect arrives.
      if (redirect_valid && (state_r != ST_HALT)) begin
         pc_s        = redirect_pc;
         out_valid_s = 1'b0;
         if (mis_s) begin
            fault_s = 1'b1;
         end else begin
            fault_s = fault_r;
         end
      end else begin
         fault_s = fault_r;
      end

      req_valid_s = (state_s == ST_REQ);
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         pc_r        <= RESET_PC;
         kill_r      <= 1'b0;
         req_valid_r <= 1'b0;
         out_valid_r <= 1'b0;
         out_pc_r    <= {ADDR_W{1'b0}};
         out_inst_r  <= {INST_W{1'b0}};
         fault_r     <= 1'b0;
      end else begin
         state_r     <= state_s;
         pc_r        <= pc_s;
         kill_r      <= kill_s;
         req_valid_r <= req_valid_s;
         out_valid_r <= out_valid_s;
         out_pc_r    <= out_pc_s;
         out_inst_r  <= out_inst_s;
         fault_r     <= fault_s;
      end
   end

   assign mem_req_valid = req_valid_r;
   assign mem_req_addr  = pc_r;
   assign out_valid     = out_valid_r;
   assign out_pc        = out_pc_r;
   assign out_inst      = out_inst_r;
   assign fetch_fault   = fault_r;

endmodule

// File: tb/tb_ifu_fetch.sv
// Scoreboard bench for ifu_fetch: stimulus queues expected requests/outputs,
// monitors pop and compare at the falling edge.
module tb_ifu_fetch;
   localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mem_req_valid;
   logic        mem_req_ready = 1'b1;
   logic [63:0] mem_req_addr;
   logic        mem_resp_valid = 1'b0;
   logic [31:0] mem_resp_data = 32'h0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] out_pc;
   logic [31:0] out_inst;
   logic        redirect_valid = 1'b0;
   logic [63:0] redirect_pc = 64'h0;
   logic        halt = 1'b0;
   logic        fetch_fault;

   int checks = 0;
   int failures = 0;
   int out_count = 0;
   int resp_delay = 1;
   logic [63:0] exp_addr_q[$];
   logic [95:0] exp_out_q[$];

   always #5 clk = ~clk;

   ifu_fetch #(.ADDR_W(64), .INST_W(32), .RESET_PC(RST_PC)) dut (
      .clk(clk), .rst_n(rst_n),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .halt(halt), .fetch_fault(fetch_fault)
   );

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return a[31:0] ^ 32'h5A5A_0013;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_fetch(input logic [63:0] a, input bit with_out);
      exp_addr_q.push_back(a);
      if (with_out) exp_out_q.push_back({a, mem_word(a)});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_out_valid(input string name);
      int n;
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 60) begin
         @(negedge clk);
         n++;
      end
      check(name, 64'(out_valid), 64'd1);
   endtask

   task automatic wait_req_accept(input string name);
      int n;
      n = 0;
      @(negedge clk);
      while (!(mem_req_valid && mem_req_ready) && n < 60) begin
         @(negedge clk);
         n++;
      end
      check(name, 64'(mem_req_valid), 64'd1);
   endtask

   task automatic wait_outs(input int target);
      int n;
      n = 0;
      @(posedge clk);
      while (out_count < target && n < 100) begin
         @(posedge clk);
         n++;
      end
      #1;
      check("out_count", 64'(out_count), 64'(target));
   endtask

   task automatic accept_one(input string name);
      wait_out_valid(name);
      step();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   // Memory model: answers each accepted request after resp_delay cycles.
   initial begin : memory
      bit          acc;
      bit          rst_seen;
      logic [63:0] a;
      logic [63:0] pend_addr;
      int          cnt;
      cnt = 0;
      pend_addr = 64'h0;
      forever begin
         @(negedge clk);
         acc = rst_n && mem_req_valid && mem_req_ready;
         rst_seen = !rst_n;
         a = mem_req_addr;
         @(posedge clk);
         #1;
         if (cnt > 0) cnt--;
         if (rst_seen) cnt = 0;
         if (acc) begin
            cnt = resp_delay;
            pend_addr = a;
         end
         mem_resp_valid = (cnt == 1);
         mem_resp_data = (cnt == 1) ? mem_word(pend_addr) : 32'h0;
      end
   end

   // Scoreboard monitors for request addresses and decoder handshakes.
   initial begin : monitor
      logic [95:0] e;
      forever begin
         @(negedge clk);
         if (rst_n && mem_req_valid && mem_req_ready) begin
            if (exp_addr_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL req_unexpected: got addr %0h expected no request", mem_req_addr);
            end else begin
               check("req_addr", mem_req_addr, exp_addr_q.pop_front());
            end
         end
         if (rst_n && out_valid && out_ready && !redirect_valid) begin
            out_count++;
            if (exp_out_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL out_unexpected: got pc %0h inst %0h expected none", out_pc, out_inst);
            end else begin
               e = exp_out_q.pop_front();
               check("out_pc", out_pc, e[95:32]);
               check("out_inst", 64'(out_inst), 64'(e[31:0]));
            end
         end
      end
   end

   initial begin : stimulus
      repeat (2) @(negedge clk);
      check("rst_req_valid", 64'(mem_req_valid), 64'd0);
      check("rst_req_addr", mem_req_addr, RST_PC);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_pc", out_pc, 64'd0);
      check("rst_out_inst", 64'(out_inst), 64'd0);
      check("rst_fault", 64'(fetch_fault), 64'd0);

      // Zero-wait streaming from RESET_PC
      push_fetch(64'h8000_0000, 1'b1);
      push_fetch(64'h8000_0004, 1'b1);
      push_fetch(64'h8000_0008, 1'b1);
      push_fetch(64'h8000_000C, 1'b1);
      step();
      out_ready = 1'b1;
      rst_n = 1'b1;
      wait_outs(3);
      out_ready = 1'b0;

      // Back-pressure in HOLD
      wait_out_valid("s2_hold");
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         check("s2_valid", 64'(out_valid), 64'd1);
         check("s2_pc", out_pc, 64'h8000_000C);
         check("s2_inst", 64'(out_inst), 64'(mem_word(64'h8000_000C)));
         check("s2_no_req", 64'(mem_req_valid), 64'd0);
      end
      push_fetch(64'h8000_0010, 1'b0);
      resp_delay = 3;
      step();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;

      // Redirect while WAIT, stale response two cycles later
      push_fetch(64'h8000_0100, 1'b0);
      wait_req_accept("s3_accept");
      step();
      redirect_valid = 1'b1;
      redirect_pc = 64'h8000_0100;
      step();
      redirect_valid = 1'b0;
      resp_delay = 1;

      // Redirect coincident with decoder handshake
      wait_out_valid("s4_hold");
      check("s4_pc", out_pc, 64'h8000_0100);
      check("s4_inst", 64'(out_inst), 64'(mem_word(64'h8000_0100)));
      push_fetch(64'h8000_0200, 1'b1);
      push_fetch(64'h8000_0204, 1'b0);
      step();
      out_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 64'h8000_0200;
      step();
      out_ready = 1'b0;
      redirect_valid = 1'b0;
      @(negedge clk);
      check("s4_dropped", 64'(out_valid), 64'd0);
      accept_one("s4_next");

      // PC wrap at the top of the address space
      wait_out_valid("s5_hold204");
      check("s5_pc204", out_pc, 64'h8000_0204);
      push_fetch(64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
      push_fetch(64'h0000_0000_0000_0000, 1'b0);
      step();
      redirect_valid = 1'b1;
      redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
      step();
      redirect_valid = 1'b0;
      accept_one("s5_top");
      wait_out_valid("s5_wrap");
      check("s5_wrap_pc", out_pc, 64'h0);
      check("s5_wrap_inst", 64'(out_inst), 64'(mem_word(64'h0)));

      // Misaligned redirect
      step();
      redirect_valid = 1'b1;
      redirect_pc = 64'h8000_0102;
      step();
      redirect_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("s5_fault", 64'(fetch_fault), 64'd1);
         check("s5_no_req", 64'(mem_req_valid), 64'd0);
         check("s5_no_out", 64'(out_valid), 64'd0);
      end

      // Reset clears the fault; halt during WAIT
      step();
      rst_n = 1'b0;
      @(negedge clk);
      check("s6_rst_fault", 64'(fetch_fault), 64'd0);
      check("s6_rst_addr", mem_req_addr, RST_PC);
      step();
      rst_n = 1'b1;
      push_fetch(RST_PC, 1'b1);
      wait_req_accept("s6_accept");
      step();
      halt = 1'b1;
      accept_one("s6_hold");
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("s6_halt_req", 64'(mem_req_valid), 64'd0);
         check("s6_halt_out", 64'(out_valid), 64'd0);
      end

      // Restart after reset pulse
      step();
      rst_n = 1'b0;
      halt = 1'b0;
      step();
      rst_n = 1'b1;
      push_fetch(RST_PC, 1'b0);
      wait_out_valid("s6_restart");
      check("s6_restart_pc", out_pc, RST_PC);
      check("s6_restart_inst", 64'(out_inst), 64'(mem_word(RST_PC)));

      check("addr_q_empty", 64'(exp_addr_q.size()), 64'd0);
      check("out_q_empty", 64'(exp_out_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
